// File: rtl/product_accumulator.sv
// Frame accumulator behind the Booth multiplier: saturating sum, term count and sticky
// saturation flag per in_last-delimited frame, presented over a valid/ready handshake.
module product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int CNT_W     = 8,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  localparam logic S_ACC  = 1'b0;
  localparam logic S_HOLD = 1'b1;

  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

  logic             state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_clamped;
  logic             clamp;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  assign in_ready  = (state == S_ACC) & ~clr;
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid & in_ready;

  // One extra bit of headroom exposes overflow before clamping.
  always_comb begin
    operand     = '0;
    sum_wide    = '0;
    clamp       = 1'b0;
    sum_clamped = '0;
    if (SIGNED_IN) begin
      operand     = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
      sum_wide    = {acc[ACC_W-1], acc} + {operand[ACC_W-1], operand};
      clamp       = sum_wide[ACC_W] != sum_wide[ACC_W-1];
      sum_clamped = sum_wide[ACC_W-1:0];
      if (clamp) sum_clamped = sum_wide[ACC_W] ? S_MIN : S_MAX;
    end else begin
      operand     = {{(ACC_W-PROD_W){1'b0}}, in_prod};
      sum_wide    = {1'b0, acc} + {1'b0, operand};
      clamp       = sum_wide[ACC_W];
      sum_clamped = clamp ? U_MAX : sum_wide[ACC_W-1:0];
    end
  end

  assign cnt_next = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      // Abort drops the running frame and any held result; out_* keep stale data.
      state <= S_ACC;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            if (in_last) begin
              out_sum   <= sum_clamped;
              out_count <= cnt_next;
              out_sat   <= sat | clamp;
              acc       <= '0;
              cnt       <= '0;
              sat       <= 1'b0;
              state     <= S_HOLD;
            end else begin
              acc <= sum_clamped;
              cnt <= cnt_next;
              sat <= sat | clamp;
            end
          end
        end
        default: begin
          if (out_ready) state <= S_ACC;
        end
      endcase
    end
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the combinational 4x4 Booth multiplier.
- Consumes its 8-bit product stream, one product per handshake, grouped into frames delimited by in_last.
- Accumulates each frame into a saturating ACC_W-bit sum and presents it with a term count and a saturation flag over a valid/ready output handshake.
- Used as the multiply-accumulate back end for dot-product style sequences.

Parameters:
PROD_W, 8, product width from the multiplier.
ACC_W, 12, accumulator and output sum width; must satisfy ACC_W > PROD_W.
CNT_W, 8, term-counter width.
SIGNED_IN, 1, 1 = in_prod is two's complement (sign-extend, signed saturation); 0 = unsigned (zero-extend, unsigned saturation).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous frame abort; takes priority over everything except reset.
in_valid  input  1  in_prod/in_last valid.
in_ready  output  1  block can accept a product this cycle.
in_prod  input  PROD_W  product from the Booth multiplier.
in_last  input  1  marks the final product of a frame.
out_valid  output  1  frame result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  ACC_W  saturated frame sum.
out_count  output  CNT_W  number of products in the frame, saturating at 2^CNT_W-1.
out_sat  output  1  sticky: saturation occurred at any point in the frame.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - State = S_ACC; accumulator, counter and internal sat = 0.
  - out_valid = 0; out_sum, out_count, out_sat = 0; in_ready = 1 after reset release.
- States:
  - S_ACC: in_ready = ~clr.
  - S_HOLD: in_ready = 0, out_valid = 1.
- Accept event: in_valid & in_ready at a rising edge.
- Extension: operand is in_prod sign-extended (SIGNED_IN=1) or zero-extended (SIGNED_IN=0) to ACC_W.
- Sum computation: sum = acc + operand, computed at ACC_W+1 bits, then clamped.
  - Signed range: [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned range: [0, 2^ACC_W-1].
  - Clamping sets internal sat.
  - Once clamped, later terms still add to the clamped value (no wrap).
- Accept with in_last=0, in S_ACC: acc <= sum; count <= count+1 (saturating); sat <= sat | clamp.
- Accept with in_last=1, in S_ACC:
  - Load final sum, count+1 and sat|clamp into out_sum, out_count, out_sat.
  - Clear acc, count and sat; go to S_HOLD.
  - out_valid rises the cycle after the accept (latency 1).
- S_HOLD:
  - Outputs held stable while out_ready=0; in_valid is ignored.
  - out_valid & out_ready: go to S_ACC next cycle; out_valid deasserts; in_ready reasserts (one-cycle bubble between frames).
  - out_sum, out_count, out_sat keep their last values after handshake.
- clr=1 (any state):
  - Next cycle: state = S_ACC, acc/count/sat = 0, out_valid = 0.
  - A simultaneous in_valid is not accepted (in_ready is 0 while clr=1).
  - A held result is discarded.
- Reset asserted mid-frame or mid-hold: immediate return to reset values; no partial result is emitted.
- Single-term frames (in_last on the first beat) are legal.
- A frame of zero terms is impossible.

Test Plan:
- Unsigned frame, SIGNED_IN=0: products 4, 9, 12 (last), out_ready=1 -> out_valid one cycle after last accept; out_sum=25, out_count=3, out_sat=0.
- Signed frame: products 15, 8'hF4 (-12), 9 (last) -> out_sum=12, out_count=3, out_sat=0.
- Saturation, SIGNED_IN=1, ACC_W=12:
  - 17 x 127 (last) -> out_sum=2047 (12'h7FF), out_sat=1, out_count=17.
  - 17 x 8'h80 -> out_sum=-2048 (12'h800), out_sat=1.
- Backpressure: frame {1, 1 (last)}, out_ready=0 for 5 cycles while in_valid=1 -> out_sum=2 stable, in_ready=0, nothing accepted; out_ready=1 -> out_valid falls next cycle, in_ready rises.
- Abort: products 3, 5, then clr=1 with in_valid=1 -> input not accepted; next frame {2 (last)} -> out_sum=2, out_count=1.
- Async reset: rst_n pulsed low mid-cycle during S_HOLD -> out_valid=0 and all outputs 0 immediately, without a clock edge.
- Back-to-back single-term frames: in_last=1 on every beat, out_ready=1 -> results every 2 cycles, out_count=1 each.
